// File: rtl/uart_int_ctrl.sv
// uart_int_ctrl
// 16550-style interrupt identification logic for the UART core.
// Prioritises the five interrupt sources (RLS > RDA > CTI > THRE > MS),
// registers the IIR value and the interrupt line, and owns the RX
// character-timeout counter and the THRE interrupt flag.
`timescale 1ns/1ps

module uart_int_ctrl #(
   parameter int OSR           = 16,  // baud_pulse ticks per serial bit
   parameter int TIMEOUT_CHARS = 4,   // idle character times before char-timeout
   parameter int CNT_W         = 12   // must hold TIMEOUT_CHARS*OSR*12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse_i,
   input  logic [3:0] ier_i,          // {edssi, elsi, etbei, erbfi}
   input  logic       fifo_en_i,
   input  logic [1:0] wls_i,
   input  logic       pen_i,
   input  logic       stb_i,
   input  logic       lsr_err_i,
   input  logic [4:0] rx_count_i,
   input  logic [4:0] rx_trig_i,
   input  logic       rx_push_i,
   input  logic       rx_pop_i,
   input  logic       tx_empty_i,
   input  logic       thr_wr_i,
   input  logic       iir_rd_i,
   input  logic       msr_delta_i,
   output logic [7:0] iir_o,
   output logic       intr_o,
   output logic       timeout_o
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   // Ticks in one bit-time multiplied by the number of idle characters;
   // the per-character bit count is applied at run time from LCR.
   localparam int CHAR_TICKS = TIMEOUT_CHARS * OSR;

   // IIR low nibble {id[2:0], n_pend} for each source.
   localparam logic [3:0] ID_RLS  = 4'b0110;
   localparam logic [3:0] ID_RDA  = 4'b0100;
   localparam logic [3:0] ID_CTI  = 4'b1100;
   localparam logic [3:0] ID_THRE = 4'b0010;
   localparam logic [3:0] ID_MS   = 4'b0000;
   localparam logic [3:0] ID_NONE = 4'b0001;

   localparam logic [7:0] IIR_RESET = 8'h01;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------

   // Serial frame length in bits: start + data(5..8) + parity + stop(1..2).
   function automatic logic [3:0] f_char_bits(
      input logic [1:0] wls,
      input logic       pen,
      input logic       stb
   );
      logic [3:0] data_bits;
      case (wls)
         2'd0:    data_bits = 4'd5;
         2'd1:    data_bits = 4'd6;
         2'd2:    data_bits = 4'd7;
         2'd3:    data_bits = 4'd8;
         default: data_bits = 4'd8;
      endcase
      return 4'd1 + data_bits + {3'b000, pen} + {3'b000, stb} + 4'd1;
   endfunction

   // Fixed-priority arbiter returning the IIR low nibble.
   function automatic logic [3:0] f_prio(
      input logic rls,
      input logic rda,
      input logic cti,
      input logic thre,
      input logic ms
   );
      logic [3:0] id;
      if (rls) begin
         id = ID_RLS;
      end else if (rda) begin
         id = ID_RDA;
      end else if (cti) begin
         id = ID_CTI;
      end else if (thre) begin
         id = ID_THRE;
      end else if (ms) begin
         id = ID_MS;
      end else begin
         id = ID_NONE;
      end
      return id;
   endfunction

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             r_thre;
   logic             r_thre_src;
   logic [7:0]       r_iir;
   logic             r_intr;

   logic [3:0]       w_char_bits;
   logic [CNT_W-1:0] w_limit;
   logic             w_rx_empty;
   logic             w_rx_clr;
   logic             w_cnt_at_limit;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout_nxt;

   logic             w_thre_src;
   logic             w_thre_set;
   logic             w_thre_clr;
   logic             w_thre_nxt;

   logic             w_src_rls;
   logic             w_rda_lvl;
   logic             w_src_rda;
   logic             w_src_cti;
   logic             w_src_thre;
   logic             w_src_ms;
   logic [3:0]       w_id;
   logic [7:0]       w_iir_nxt;

   // ------------------------------------------------------------------
   // Character-timeout counter and flag
   // ------------------------------------------------------------------
   assign w_char_bits    = f_char_bits(wls_i, pen_i, stb_i);
   assign w_limit        = CNT_W'(CHAR_TICKS) * {{(CNT_W-4){1'b0}}, w_char_bits};
   assign w_rx_empty     = (rx_count_i == 5'd0);
   // Any FIFO activity, or an empty FIFO, restarts the idle measurement.
   assign w_rx_clr       = w_rx_empty | rx_push_i | rx_pop_i;
   // ">=" keeps the flag raised if LCR shrinks the limit below a held count.
   assign w_cnt_at_limit = (r_cnt >= w_limit);

   // Next counter value: clear on FIFO activity, else count baud ticks up to the limit.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_rx_clr) begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end else if (baud_pulse_i && !w_cnt_at_limit) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Next timeout flag: set the cycle after the counter sits at the limit; clear wins.
   always_comb begin
      w_timeout_nxt = r_timeout;
      if (w_rx_clr) begin
         w_timeout_nxt = 1'b0;
      end else if (w_cnt_at_limit) begin
         w_timeout_nxt = 1'b1;
      end else begin
         w_timeout_nxt = r_timeout;
      end
   end

   // Timeout counter and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= {CNT_W{1'b0}};
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------
   // THRE interrupt flag
   // ------------------------------------------------------------------
   // The flag is raised by a rising edge of (tx_empty & etbei), so enabling
   // etbei while the THR is already empty also produces an interrupt.
   assign w_thre_src = tx_empty_i & ier_i[1];
   assign w_thre_set = w_thre_src & ~r_thre_src;
   // Reading the IIR only acknowledges THRE when THRE is what the IIR showed.
   assign w_thre_clr = thr_wr_i | (iir_rd_i & (r_iir[3:0] == ID_THRE));

   // Next THRE flag: clear beats a simultaneous set; masking etbei leaves it alone.
   always_comb begin
      w_thre_nxt = r_thre;
      if (w_thre_clr) begin
         w_thre_nxt = 1'b0;
      end else if (w_thre_set) begin
         w_thre_nxt = 1'b1;
      end else begin
         w_thre_nxt = r_thre;
      end
   end

   // THRE flag and the edge-detect history of its source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_thre     <= 1'b0;
         r_thre_src <= 1'b0;
      end else begin
         r_thre     <= w_thre_nxt;
         r_thre_src <= w_thre_src;
      end
   end

   // ------------------------------------------------------------------
   // Source qualification and priority
   // ------------------------------------------------------------------
   assign w_src_rls  = ier_i[2] & lsr_err_i;
   assign w_rda_lvl  = fifo_en_i ? (rx_count_i >= rx_trig_i) : ~w_rx_empty;
   assign w_src_rda  = ier_i[0] & w_rda_lvl;
   // The internal flags feed the arbiter from their next-state values so the
   // IIR and the flags change on the same edge; an IIR read therefore never
   // sees a THRE indication that has already been acknowledged.
   assign w_src_cti  = ier_i[0] & fifo_en_i & w_timeout_nxt;
   assign w_src_thre = ier_i[1] & w_thre_nxt;
   assign w_src_ms   = ier_i[3] & msr_delta_i;

   assign w_id      = f_prio(w_src_rls, w_src_rda, w_src_cti, w_src_thre, w_src_ms);
   assign w_iir_nxt = {fifo_en_i, fifo_en_i, 2'b00, w_id};

   // Registered IIR value and interrupt request line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iir  <= IIR_RESET;
         r_intr <= 1'b0;
      end else begin
         r_iir  <= w_iir_nxt;
         r_intr <= ~w_id[0];
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign iir_o     = r_iir;
   assign intr_o    = r_intr;
   assign timeout_o = r_timeout;

endmodule
